// File: rtl/exec_sequencer_pkg.sv
// Shared constants and types for the instruction-execution sequencer.
// Stage and ALU-operation encodings are common to the datapath blocks.
package exec_sequencer_pkg;

    localparam int MEMORY_DATA_BITS         = 8;
    localparam int MEMORY_ADDRESS_BITS      = 8;
    localparam int INSTRUCTION_POINTER_BITS = 8;
    localparam int JUMP_OFFSET_BITS         = 8;
    localparam int OPCODE_BITS              = 4;
    localparam int INSTR_WORDS_DEFAULT      = 2;

    // Low instruction field that carries either the immediate or the jump offset
    localparam int OPERAND_BITS = (MEMORY_ADDRESS_BITS > JUMP_OFFSET_BITS) ?
                                  MEMORY_ADDRESS_BITS : JUMP_OFFSET_BITS;

    typedef enum logic [2:0] {
        IDLE              = 3'd0,
        INSTR_FETCH_START = 3'd1,
        INSTR_FETCH_END   = 3'd2,
        REGISTER_FETCH    = 3'd3,
        EXECUTE           = 3'd4,
        REGISTER_WB       = 3'd5,
        LOAD_STAGE        = 3'd6,
        STORE_STAGE       = 3'd7
    } ExecutionStage;

    typedef enum logic [1:0] {
        REG_READ  = 2'd0,
        REG_WRITE = 2'd1,
        ADD       = 2'd2,
        SUB       = 2'd3
    } ALUOp;

    typedef enum logic [OPCODE_BITS-1:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_LOAD  = 4'd3,
        OP_STORE = 4'd4,
        OP_JMP   = 4'd5,
        OP_JZ    = 4'd6,
        OP_HALT  = 4'd7
    } Opcode;

    function automatic logic is_request_stage(input ExecutionStage s);
        return (s == INSTR_FETCH_START) || (s == LOAD_STAGE) || (s == STORE_STAGE);
    endfunction

endpackage

// File: rtl/exec_sequencer_instr_decoder.sv
// Combinational instruction decode: opcode class, immediate, signed jump offset.
// Undefined opcodes decode as NOP with the illegal flag raised.
module exec_sequencer_instr_decoder
    import exec_sequencer_pkg::*;
(
    input  logic [OPCODE_BITS-1:0]              op_field_i,
    input  logic [OPERAND_BITS-1:0]             operand_i,
    output Opcode                               opcode_o,
    output logic [MEMORY_ADDRESS_BITS-1:0]      imm_o,
    output logic [INSTRUCTION_POINTER_BITS-1:0] offset_o,
    output logic                                illegal_o
);

    // Opcodes 8-15 are exactly those with the top opcode bit set
    assign illegal_o = op_field_i[OPCODE_BITS-1];
    assign opcode_o  = illegal_o ? OP_NOP : Opcode'(op_field_i);
    assign imm_o     = operand_i[MEMORY_ADDRESS_BITS-1:0];
    assign offset_o  = INSTRUCTION_POINTER_BITS'($signed(operand_i[JUMP_OFFSET_BITS-1:0]));

endmodule

// File: rtl/exec_sequencer.sv
// Instruction-execution control unit: multi-word fetch, decode, register fetch,
// execute, write-back and load/store, with wait-state tolerance and bus timeout.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int unsigned                          INSTR_WORDS = INSTR_WORDS_DEFAULT,
    parameter int unsigned                          INSTR_BITS  = INSTR_WORDS * MEMORY_DATA_BITS,
    parameter logic [INSTRUCTION_POINTER_BITS-1:0]  RESET_IP    = '0,
    parameter int unsigned                          MEM_TIMEOUT = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [MEMORY_ADDRESS_BITS-1:0]      mem_addr,
    input  logic [MEMORY_DATA_BITS-1:0]         mem_rdata,
    input  logic                                mem_ready,
    output logic [INSTR_BITS-1:0]               instr,
    output logic [INSTRUCTION_POINTER_BITS-1:0] ip,
    output ExecutionStage                       stage,
    output logic                                rf_re,
    output logic                                rf_we,
    output ALUOp                                alu_op,
    input  logic                                alu_zero,
    output logic                                halted,
    output logic                                bus_error,
    output logic                                illegal
);

    localparam int unsigned WCW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
    localparam int unsigned TMW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(INSTR_WORDS - 1);
    localparam logic [TMW-1:0] TMO_LAST  = TMW'(MEM_TIMEOUT - 1);
    localparam logic [INSTRUCTION_POINTER_BITS-1:0] IP_STEP =
        INSTRUCTION_POINTER_BITS'(INSTR_WORDS);

    ExecutionStage                       stage_q, stage_d;
    logic [INSTRUCTION_POINTER_BITS-1:0] ip_q, ip_d;
    logic [INSTR_BITS-1:0]               instr_q, instr_d;
    logic [WCW-1:0]                      word_cnt_q, word_cnt_d;
    logic [TMW-1:0]                      tmo_q, tmo_d;
    logic                                halted_q, halted_d;
    logic                                bus_error_q, bus_error_d;

    Opcode                               dec_op;
    logic [MEMORY_ADDRESS_BITS-1:0]      dec_imm;
    logic [INSTRUCTION_POINTER_BITS-1:0] dec_offset;
    logic                                dec_illegal;
    logic [INSTRUCTION_POINTER_BITS-1:0] fetch_addr;
    logic                                req_stage;
    logic                                timeout_hit;

    exec_sequencer_instr_decoder u_decoder (
        .op_field_i (instr_q[INSTR_BITS-1 -: OPCODE_BITS]),
        .operand_i  (instr_q[OPERAND_BITS-1:0]),
        .opcode_o   (dec_op),
        .imm_o      (dec_imm),
        .offset_o   (dec_offset),
        .illegal_o  (dec_illegal)
    );

    assign fetch_addr  = ip_q + INSTRUCTION_POINTER_BITS'(word_cnt_q);
    assign req_stage   = is_request_stage(stage_q);
    assign timeout_hit = req_stage && !mem_ready && (tmo_q == TMO_LAST);

    // Moore decode of stage; the LOAD write strobe alone is qualified by
    // mem_ready so the register file captures the data in the cycle it arrives.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        rf_re    = 1'b0;
        rf_we    = 1'b0;
        alu_op   = REG_READ;
        illegal  = 1'b0;
        case (stage_q)
            INSTR_FETCH_START: begin
                mem_req  = 1'b1;
                mem_addr = MEMORY_ADDRESS_BITS'(fetch_addr);
            end
            REGISTER_FETCH: rf_re = 1'b1;
            EXECUTE: begin
                illegal = dec_illegal;
                if (dec_op == OP_ADD) begin
                    alu_op = ADD;
                end else if (dec_op == OP_SUB) begin
                    alu_op = SUB;
                end
            end
            REGISTER_WB: begin
                rf_we  = 1'b1;
                alu_op = REG_WRITE;
            end
            LOAD_STAGE: begin
                mem_req  = 1'b1;
                mem_addr = dec_imm;
                if (mem_ready) begin
                    rf_we  = 1'b1;
                    alu_op = REG_WRITE;
                end
            end
            STORE_STAGE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = dec_imm;
            end
            default: ;
        endcase
    end

    always_comb begin
        stage_d     = stage_q;
        ip_d        = ip_q;
        instr_d     = instr_q;
        word_cnt_d  = word_cnt_q;
        halted_d    = halted_q;
        bus_error_d = bus_error_q;
        tmo_d       = '0;

        if (req_stage && !mem_ready) begin
            tmo_d = tmo_q + TMW'(1);
        end

        case (stage_q)
            IDLE: begin
                if (start) begin
                    stage_d     = INSTR_FETCH_START;
                    word_cnt_d  = '0;
                    halted_d    = 1'b0;
                    bus_error_d = 1'b0;
                end
            end
            INSTR_FETCH_START: begin
                if (mem_ready) begin
                    // Word 0 lands in the MSBs of the instruction register
                    for (int unsigned w = 0; w < INSTR_WORDS; w++) begin
                        if (word_cnt_q == WCW'(w)) begin
                            instr_d[INSTR_BITS-1-w*MEMORY_DATA_BITS -: MEMORY_DATA_BITS] = mem_rdata;
                        end
                    end
                    if (word_cnt_q == LAST_WORD) begin
                        stage_d = INSTR_FETCH_END;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end
            INSTR_FETCH_END: begin
                ip_d    = ip_q + IP_STEP;
                stage_d = REGISTER_FETCH;
            end
            REGISTER_FETCH: stage_d = EXECUTE;
            EXECUTE: begin
                word_cnt_d = '0;
                case (dec_op)
                    OP_ADD, OP_SUB: stage_d = REGISTER_WB;
                    OP_LOAD:        stage_d = LOAD_STAGE;
                    OP_STORE:       stage_d = STORE_STAGE;
                    OP_JMP: begin
                        ip_d    = ip_q + dec_offset;
                        stage_d = INSTR_FETCH_START;
                    end
                    OP_JZ: begin
                        if (alu_zero) begin
                            ip_d = ip_q + dec_offset;
                        end
                        stage_d = INSTR_FETCH_START;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        stage_d  = IDLE;
                    end
                    default: stage_d = INSTR_FETCH_START;
                endcase
            end
            REGISTER_WB: begin
                word_cnt_d = '0;
                stage_d    = INSTR_FETCH_START;
            end
            LOAD_STAGE, STORE_STAGE: begin
                if (mem_ready) begin
                    word_cnt_d = '0;
                    stage_d    = INSTR_FETCH_START;
                end
            end
            default: stage_d = IDLE;
        endcase

        if (timeout_hit) begin
            stage_d     = IDLE;
            halted_d    = 1'b1;
            bus_error_d = 1'b1;
            tmo_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q     <= IDLE;
            ip_q        <= RESET_IP;
            instr_q     <= '0;
            word_cnt_q  <= '0;
            tmo_q       <= '0;
            halted_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            ip_q        <= ip_d;
            instr_q     <= instr_d;
            word_cnt_q  <= word_cnt_d;
            tmo_q       <= tmo_d;
            halted_q    <= halted_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign instr     = instr_q;
    assign ip        = ip_q;
    assign stage     = stage_q;
    assign halted    = halted_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: cycle trace table for a zero-wait ADD,
// plus hand sequences for jumps, wait states, timeout, halt and illegal opcodes.
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          alu_zero = 1'b0;
    logic          mem_req, mem_we, mem_ready, rf_re, rf_we;
    logic          halted, bus_error, illegal;
    logic [7:0]    mem_addr, mem_rdata, ip;
    logic [15:0]   instr;
    ExecutionStage stage;
    ALUOp          alu_op;

    logic [7:0]    mem [256];
    int            wait_states = 0;
    logic          stuck = 1'b0;
    int            wcnt = 0;

    int checks = 0;
    int errors = 0;
    int n, held, pulses, bad;

    typedef struct {
        logic          start;
        ExecutionStage stage;
        logic          mem_req;
        logic [7:0]    mem_addr;
        logic          rf_re;
        logic          rf_we;
        ALUOp          alu;
        logic [15:0]   instr;
        logic [7:0]    ip;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    // Memory model: ready after wait_states idle cycles of a held request
    assign mem_rdata = mem[mem_addr];
    assign mem_ready = mem_req && !stuck && (wcnt == wait_states);
    always @(posedge clk) begin
        if (!mem_req || mem_ready) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    exec_sequencer #(
        .INSTR_WORDS (2),
        .RESET_IP    (8'h00),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .instr     (instr),
        .ip        (ip),
        .stage     (stage),
        .rf_re     (rf_re),
        .rf_we     (rf_we),
        .alu_op    (alu_op),
        .alu_zero  (alu_zero),
        .halted    (halted),
        .bus_error (bus_error),
        .illegal   (illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_stage(input ExecutionStage s, input int budget, input string name);
        int k;
        k = 0;
        while (stage != s && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (stage != s) begin
            errors++;
            $display("FAIL %s: stage %0d never reached target %0d within %0d cycles",
                     name, stage, s, budget);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, IDLE,              1'b0, 8'h00, 1'b0, 1'b0, REG_READ,  16'h0000, 8'h00};
        vecs[1] = '{1'b0, INSTR_FETCH_START, 1'b1, 8'h00, 1'b0, 1'b0, REG_READ,  16'h0000, 8'h00};
        vecs[2] = '{1'b0, INSTR_FETCH_START, 1'b1, 8'h01, 1'b0, 1'b0, REG_READ,  16'h1000, 8'h00};
        vecs[3] = '{1'b0, INSTR_FETCH_END,   1'b0, 8'h00, 1'b0, 1'b0, REG_READ,  16'h1012, 8'h00};
        vecs[4] = '{1'b0, REGISTER_FETCH,    1'b0, 8'h00, 1'b1, 1'b0, REG_READ,  16'h1012, 8'h02};
        vecs[5] = '{1'b0, EXECUTE,           1'b0, 8'h00, 1'b0, 1'b0, ADD,       16'h1012, 8'h02};
        vecs[6] = '{1'b0, REGISTER_WB,       1'b0, 8'h00, 1'b0, 1'b1, REG_WRITE, 16'h1012, 8'h02};
        vecs[7] = '{1'b0, INSTR_FETCH_START, 1'b1, 8'h02, 1'b0, 1'b0, REG_READ,  16'h1012, 8'h02};

        // Zero-wait ADD trace
        clear_mem();
        mem[8'h00] = 8'h10;
        mem[8'h01] = 8'h12;
        do_reset();
        check("reset_flags", {halted, bus_error, illegal, rf_we, rf_re, mem_req, mem_we}, 7'b0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("trace[%0d]", i),
                  {stage, mem_req, mem_addr, rf_re, rf_we, alu_op, instr, ip},
                  {vecs[i].stage, vecs[i].mem_req, vecs[i].mem_addr, vecs[i].rf_re,
                   vecs[i].rf_we, vecs[i].alu, vecs[i].instr, vecs[i].ip});
            start = vecs[i].start;
            step();
        end

        // Reset while a LOAD request is outstanding
        clear_mem();
        mem[8'h00] = 8'h30;
        mem[8'h01] = 8'h80;
        wait_states = 5;
        do_reset();
        pulse_start();
        wait_stage(LOAD_STAGE, 60, "midload_reach");
        check("midload_req", {mem_req, mem_addr}, {1'b1, 8'h80});
        reset = 1'b1;
        step();
        check("midload_reset", {stage, mem_req, rf_we, halted, ip}, {IDLE, 1'b0, 1'b0, 1'b0, 8'h00});
        reset = 1'b0;

        // JMP with ip wrap-around, then HALT
        clear_mem();
        wait_states = 0;
        mem[8'h00] = 8'h50; mem[8'h01] = 8'hFC;
        mem[8'hFE] = 8'h50; mem[8'hFF] = 8'hFC;
        mem[8'hFC] = 8'h70; mem[8'hFD] = 8'h00;
        do_reset();
        pulse_start();
        wait_stage(EXECUTE, 20, "jmp1_ex");
        check("jmp1_no_illegal", {illegal}, 1'b0);
        step();
        check("jmp1_target", {stage, ip, mem_addr}, {INSTR_FETCH_START, 8'hFE, 8'hFE});
        wait_stage(REGISTER_FETCH, 20, "jmp2_rf");
        check("jmp2_ipwrap", ip, 8'h00);
        step();
        step();
        check("jmp2_target", {stage, ip, mem_addr}, {INSTR_FETCH_START, 8'hFC, 8'hFC});
        wait_stage(IDLE, 20, "halt_idle");
        check("halt_flags", {halted, bus_error, ip}, {1'b1, 1'b0, 8'hFE});

        // JZ not taken / taken
        clear_mem();
        mem[8'h00] = 8'h50; mem[8'h01] = 8'h0E;
        mem[8'h10] = 8'h60; mem[8'h11] = 8'h03;
        mem[8'h12] = 8'h70; mem[8'h13] = 8'h00;
        mem[8'h15] = 8'h70; mem[8'h16] = 8'h00;
        alu_zero = 1'b0;
        do_reset();
        pulse_start();
        wait_stage(EXECUTE, 20, "jz0_jmp_ex");
        step();
        check("jz0_at_10", {stage, ip}, {INSTR_FETCH_START, 8'h10});
        wait_stage(EXECUTE, 20, "jz0_ex");
        step();
        check("jz_not_taken", {stage, mem_addr}, {INSTR_FETCH_START, 8'h12});
        wait_stage(IDLE, 20, "jz0_halt");
        alu_zero = 1'b1;
        do_reset();
        pulse_start();
        wait_stage(EXECUTE, 20, "jz1_jmp_ex");
        step();
        wait_stage(EXECUTE, 20, "jz1_ex");
        step();
        check("jz_taken", {stage, ip, mem_addr}, {INSTR_FETCH_START, 8'h15, 8'h15});
        wait_stage(IDLE, 20, "jz1_halt");
        alu_zero = 1'b0;

        // LOAD and STORE with three wait states
        clear_mem();
        mem[8'h00] = 8'h30; mem[8'h01] = 8'h80;
        mem[8'h02] = 8'h40; mem[8'h03] = 8'h33;
        mem[8'h04] = 8'h70; mem[8'h05] = 8'h00;
        wait_states = 3;
        do_reset();
        pulse_start();
        wait_stage(LOAD_STAGE, 60, "load_reach");
        held = 0; pulses = 0; bad = 0; n = 0;
        while (stage == LOAD_STAGE && n < 20) begin
            if (mem_req && !mem_we && mem_addr == 8'h80) held++;
            if (rf_we) begin
                pulses++;
                if (!mem_ready || alu_op != REG_WRITE) bad++;
            end
            step();
            n++;
        end
        check("load_hold_cycles", held, 4);
        check("load_rfwe_pulses", pulses, 1);
        check("load_rfwe_coincident", bad, 0);
        check("load_next_fetch", {stage, mem_addr}, {INSTR_FETCH_START, 8'h02});
        wait_stage(STORE_STAGE, 60, "store_reach");
        check("store_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 8'h33});
        wait_stage(IDLE, 80, "store_halt");

        // Bus timeout with mem_ready stuck low
        wait_states = 0;
        stuck = 1'b1;
        do_reset();
        pulse_start();
        n = 0;
        while (stage == INSTR_FETCH_START && n < 40) begin
            step();
            n++;
        end
        check("timeout_cycles", n, 16);
        check("timeout_flags", {stage, bus_error, halted, ip}, {IDLE, 1'b1, 1'b1, 8'h00});

        // Restart clears sticky flags; undefined opcode pulses illegal
        stuck = 1'b0;
        clear_mem();
        mem[8'h00] = 8'hA0; mem[8'h01] = 8'h00;
        mem[8'h02] = 8'h70; mem[8'h03] = 8'h00;
        pulse_start();
        check("restart_clears", {halted, bus_error, stage}, {1'b0, 1'b0, INSTR_FETCH_START});
        wait_stage(EXECUTE, 20, "illegal_ex");
        check("illegal_pulse", {illegal, alu_op}, {1'b1, REG_READ});
        step();
        check("illegal_after", {illegal, stage, mem_addr}, {1'b0, INSTR_FETCH_START, 8'h02});
        wait_stage(IDLE, 20, "illegal_halt");
        check("illegal_halt_flags", {halted, bus_error}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
